record_core_mc: RTL and testbench

- Parametrised successor to the single-target recording core.
- Captures microphone samples from the audio codec interface into a small elastic FIFO, then writes them to SDRAM at one of NUM_SLOTS selectable track base addresses.
- Two modes: overwrite, and overdub (read-mix-write with signed saturation).
- Supports pause/resume, stop with FIFO drain, per-take length limit and sample count report. Sits between the top-level controller, the SDRAM arbiter port and the audio codec receiver.

---
 rtl/record_pkg.sv | 32 +++
 rtl/record_fifo.sv | 50 +++++
 rtl/record_core_mc.sv | 191 +++++++++++++++++++
 tb/tb_record_core_mc.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/record_pkg.sv
// Shared state encoding, mode constants and saturating arithmetic for the
// multi-slot recording core.
package record_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_WR,
    ST_FLUSH,
    ST_DONE
  } record_state_t;

  localparam logic MODE_OVERWRITE = 1'b0;
  localparam logic MODE_OVERDUB   = 1'b1;

  // Signed add clamped to the range of a w-bit two's complement value (w <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi)      sat_add = hi;
    else if (sum < lo) sat_add = lo;
    else               sat_add = sum;
  endfunction

endpackage

// File: rtl/record_fifo.sv
// First-word-fall-through elastic buffer between the codec receiver and the
// SDRAM write engine; clear has priority over push/pop.
module record_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/record_core_mc.sv
// Multi-slot recording core: buffers codec samples and writes them to SDRAM at a
// selectable track base, either overwriting or mixing into the existing take.
module record_core_mc
  import record_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 16,
  parameter int NUM_SLOTS  = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             record_start,
  input  logic [NUM_SLOTS-1:0][ADDR_W-1:0] record_select,
  input  logic [SLOT_W-1:0]                record_slot,
  input  logic                             record_mode,
  input  logic [ADDR_W-1:0]                record_limit,
  input  logic                             record_pause,
  input  logic                             record_stop,
  output logic                             record_done,
  output logic                             record_busy,
  output logic                             record_paused,
  output logic [ADDR_W-1:0]                record_length,
  output logic                             record_overflow,
  output logic                             record_read,
  output logic                             record_write,
  output logic [ADDR_W-1:0]                record_addr,
  input  logic [DATA_W-1:0]                record_readdata,
  output logic [DATA_W-1:0]                record_writedata,
  input  logic                             record_sdram_finished,
  output logic                             record_sdram_fresh,
  output logic                             record_audio_ready,
  input  logic [DATA_W-1:0]                record_audio_data,
  input  logic                             record_audio_valid
);

  record_state_t            state;
  record_state_t            state_nxt;
  logic                     mode_q;
  logic [ADDR_W-1:0]        limit_q;
  logic [ADDR_W-1:0]        base_q;
  logic [ADDR_W-1:0]        length_q;
  logic [ADDR_W-1:0]        length_inc;
  logic                     paused_q;
  logic                     stopping_q;
  logic                     overflow_q;
  logic                     fresh_q;
  logic                     gap_q;
  logic signed [DATA_W-1:0] wdata_q;

  logic                     busy;
  logic                     start_acc;
  logic                     stop_acc;
  logic                     pause_acc;
  logic                     xfer_done;
  logic                     limit_hit;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_clear;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [DATA_W-1:0]        fifo_dout;

  assign busy       = state inside {ST_WAIT, ST_RD, ST_WR, ST_FLUSH};
  assign start_acc  = record_start && (state == ST_IDLE);
  assign stop_acc   = record_stop && busy && !stopping_q;
  assign pause_acc  = record_pause && busy && !stopping_q && !record_stop;
  assign xfer_done  = record_sdram_finished && !gap_q;
  assign length_inc = length_q + 1'b1;
  assign limit_hit  = (limit_q != '0) && (length_inc == limit_q);
  assign fifo_push  = record_audio_valid && record_audio_ready;

  record_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (i_clk),
    .rst_n(i_rst),
    .clear(fifo_clear),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (record_audio_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (record_start) begin
          fifo_clear = 1'b1;
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT, ST_FLUSH: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = (mode_q == MODE_OVERDUB) ? ST_RD : ST_WR;
        end else if (state == ST_FLUSH) begin
          state_nxt = ST_DONE;
        end else if (stopping_q) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_RD: begin
        if (xfer_done) state_nxt = ST_WR;
      end
      ST_WR: begin
        // A reached limit discards whatever is still queued.
        if (xfer_done) begin
          if (limit_hit) begin
            fifo_clear = 1'b1;
            state_nxt  = ST_DONE;
          end else if (stopping_q || stop_acc) begin
            state_nxt = ST_FLUSH;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mode_q     <= MODE_OVERWRITE;
      limit_q    <= '0;
      base_q     <= '0;
      length_q   <= '0;
      paused_q   <= 1'b0;
      stopping_q <= 1'b0;
      overflow_q <= 1'b0;
      fresh_q    <= 1'b0;
      gap_q      <= 1'b0;
      wdata_q    <= '0;
    end else begin
      fresh_q <= 1'b0;
      if (start_acc) begin
        mode_q     <= record_mode;
        limit_q    <= record_limit;
        base_q     <= record_select[record_slot];
        length_q   <= '0;
        paused_q   <= 1'b0;
        stopping_q <= 1'b0;
        overflow_q <= 1'b0;
        fresh_q    <= 1'b1;
      end else begin
        if (stop_acc) begin
          stopping_q <= 1'b1;
          paused_q   <= 1'b0;
        end else if (pause_acc) begin
          paused_q <= !paused_q;
        end
        if (record_audio_valid && !record_audio_ready && !paused_q &&
            (state inside {ST_WAIT, ST_RD, ST_WR}))
          overflow_q <= 1'b1;
      end
      // One idle cycle separates the read from the following write.
      gap_q <= (state == ST_RD) && xfer_done;
      if (fifo_pop) wdata_q <= $signed(fifo_dout);
      if ((state == ST_RD) && xfer_done)
        wdata_q <= DATA_W'(sat_add(64'($signed(record_readdata)), 64'(wdata_q), DATA_W));
      if ((state == ST_WR) && xfer_done) length_q <= length_inc;
    end
  end

  assign record_done        = (state == ST_DONE);
  assign record_busy        = busy;
  assign record_paused      = paused_q;
  assign record_length      = length_q;
  assign record_overflow    = overflow_q;
  assign record_read        = (state == ST_RD) && !gap_q;
  assign record_write       = (state == ST_WR) && !gap_q;
  assign record_addr        = base_q + length_q;
  assign record_writedata   = wdata_q;
  assign record_sdram_fresh = fresh_q;
  assign record_audio_ready = busy && !paused_q && !stopping_q && !fifo_full;

endmodule

// File: tb/tb_record_core_mc.sv
// Directed bench for record_core_mc with a small SDRAM responder model.
module tb_record_core_mc;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              record_start;
  logic [3:0][22:0]  record_select;
  logic [1:0]        record_slot;
  logic              record_mode;
  logic [22:0]       record_limit;
  logic              record_pause;
  logic              record_stop;
  logic              record_done;
  logic              record_busy;
  logic              record_paused;
  logic [22:0]       record_length;
  logic              record_overflow;
  logic              record_read;
  logic              record_write;
  logic [22:0]       record_addr;
  logic [15:0]       record_readdata;
  logic [15:0]       record_writedata;
  logic              record_sdram_finished;
  logic              record_sdram_fresh;
  logic              record_audio_ready;
  logic [15:0]       record_audio_data;
  logic              record_audio_valid;

  record_core_mc dut (
    .i_clk                (clk),
    .i_rst                (i_rst),
    .record_start         (record_start),
    .record_select        (record_select),
    .record_slot          (record_slot),
    .record_mode          (record_mode),
    .record_limit         (record_limit),
    .record_pause         (record_pause),
    .record_stop          (record_stop),
    .record_done          (record_done),
    .record_busy          (record_busy),
    .record_paused        (record_paused),
    .record_length        (record_length),
    .record_overflow      (record_overflow),
    .record_read          (record_read),
    .record_write         (record_write),
    .record_addr          (record_addr),
    .record_readdata      (record_readdata),
    .record_writedata     (record_writedata),
    .record_sdram_finished(record_sdram_finished),
    .record_sdram_fresh   (record_sdram_fresh),
    .record_audio_ready   (record_audio_ready),
    .record_audio_data    (record_audio_data),
    .record_audio_valid   (record_audio_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SDRAM responder: finishes a request after lat extra cycles, one-cycle finished pulse.
  logic [15:0] mem [logic [22:0]];
  int          lat = 0;
  int          wait_cnt = 0;
  logic [22:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [22:0] rd_addr_q[$];
  logic [23:0] ops_q[$];
  int          both_cnt = 0;
  int          fresh_cnt = 0;
  int          done_cnt = 0;

  initial begin : sdram_model
    record_sdram_finished = 1'b0;
    record_readdata       = '0;
    forever begin
      @(negedge clk);
      if (record_read && record_write) both_cnt++;
      if (record_sdram_fresh) fresh_cnt++;
      if (record_done) done_cnt++;
      if (record_sdram_finished) begin
        record_sdram_finished = 1'b0;
      end else if (!(record_read || record_write)) begin
        wait_cnt = 0;
      end else if (wait_cnt < lat) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        ops_q.push_back({record_write, record_addr});
        if (record_write) begin
          mem[record_addr] = record_writedata;
          wr_addr_q.push_back(record_addr);
          wr_data_q.push_back(record_writedata);
        end else begin
          record_readdata = mem.exists(record_addr) ? mem[record_addr] : 16'h0000;
          rd_addr_q.push_back(record_addr);
        end
        record_sdram_finished = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic start_take(input logic [1:0] slot, input logic mode, input logic [22:0] limit);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    ops_q.delete();
    record_slot  = slot;
    record_mode  = mode;
    record_limit = limit;
    record_start = 1'b1;
    @(negedge clk);
    record_start = 1'b0;
  endtask

  task automatic push_sample(input logic [15:0] d);
    bit ok = 1'b0;
    record_audio_data  = d;
    record_audio_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = record_audio_ready;
      @(negedge clk);
    end
    record_audio_valid = 1'b0;
    if (!ok) check_val("push_timeout", ok, 1);
  endtask

  task automatic pulse_stop();
    record_stop = 1'b1;
    @(negedge clk);
    record_stop = 1'b0;
  endtask

  task automatic pulse_pause();
    record_pause = 1'b1;
    @(negedge clk);
    record_pause = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int d0   = done_cnt;
    bit seen = 1'b0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      @(negedge clk);
      seen = (done_cnt != d0);
    end
    check_val(tag, seen, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [22:0] base,
                              input logic [15:0] d0, input logic [15:0] step);
    check_val({tag, "_nwr"}, wr_addr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_addr_q.size()) begin
        check_val({tag, "_addr"}, wr_addr_q[i], 23'(base + 23'(i)));
        check_val({tag, "_data"}, wr_data_q[i], 16'(d0 + 16'(i) * step));
      end
    end
  endtask

  int f0;
  int d0;
  int nops;
  int accepted;
  bit acc_now;
  bit wr_seen;

  initial begin
    i_rst              = 1'b0;
    record_start       = 1'b0;
    record_select      = '0;
    record_slot        = '0;
    record_mode        = 1'b0;
    record_limit       = '0;
    record_pause       = 1'b0;
    record_stop        = 1'b0;
    record_audio_data  = '0;
    record_audio_valid = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst_busy", record_busy, 0);
    check_val("rst_done", record_done, 0);
    check_val("rst_ready", record_audio_ready, 0);
    check_val("rst_read", record_read, 0);
    check_val("rst_write", record_write, 0);
    check_val("rst_addr", record_addr, 0);
    check_val("rst_length", record_length, 0);
    check_val("rst_overflow", record_overflow, 0);
    check_val("rst_fresh", record_sdram_fresh, 0);
    check_val("rst_wdata", record_writedata, 0);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Overwrite into slot 2.
    record_select[2] = 23'h001000;
    lat = 0;
    f0 = fresh_cnt;
    d0 = done_cnt;
    start_take(2'd2, 1'b0, 23'd0);
    for (int k = 1; k <= 5; k++) push_sample(16'(k));
    pulse_stop();
    wait_done("t1_done", 200);
    check_writes("t1", 5, 23'h001000, 16'd1, 16'd1);
    check_val("t1_length", record_length, 5);
    check_val("t1_ndone", done_cnt - d0, 1);
    check_val("t1_nfresh", fresh_cnt - f0, 1);
    check_val("t1_nrd", rd_addr_q.size(), 0);
    check_val("t1_busy", record_busy, 0);

    // Overdub with positive and negative saturation plus one in-range mix.
    mem[23'h000200] = 16'h7000;
    mem[23'h000201] = 16'h8100;
    mem[23'h000202] = 16'h0005;
    record_select[1] = 23'h000200;
    start_take(2'd1, 1'b1, 23'd0);
    push_sample(16'h2000);
    push_sample(16'hF000);
    push_sample(16'hFFFE);
    pulse_stop();
    wait_done("t2_done", 200);
    check_val("t2_nwr", wr_data_q.size(), 3);
    if (wr_data_q.size() == 3) begin
      check_val("t2_sat_pos", wr_data_q[0], 16'h7FFF);
      check_val("t2_sat_neg", wr_data_q[1], 16'h8000);
      check_val("t2_mix", wr_data_q[2], 16'h0003);
    end
    check_val("t2_nops", ops_q.size(), 6);
    if (ops_q.size() == 6) begin
      check_val("t2_op0", ops_q[0], {1'b0, 23'h000200});
      check_val("t2_op1", ops_q[1], {1'b1, 23'h000200});
      check_val("t2_op2", ops_q[2], {1'b0, 23'h000201});
      check_val("t2_op3", ops_q[3], {1'b1, 23'h000201});
      check_val("t2_op5", ops_q[5], {1'b1, 23'h000202});
    end
    check_val("t2_length", record_length, 3);

    // Length limit of 3 with slow SDRAM.
    record_select[0] = 23'h000300;
    lat = 4;
    start_take(2'd0, 1'b0, 23'd3);
    for (int k = 1; k <= 6; k++) push_sample(16'(k));
    wait_done("t3_done", 400);
    nops = ops_q.size();
    repeat (20) @(negedge clk);
    check_writes("t3", 3, 23'h000300, 16'd1, 16'd1);
    check_val("t3_no_more_ops", ops_q.size(), nops);
    check_val("t3_length", record_length, 3);
    check_val("t3_busy", record_busy, 0);

    // Pause/resume across the top of the address space.
    record_select[3] = 23'h7FFFFE;
    lat = 0;
    f0 = fresh_cnt;
    start_take(2'd3, 1'b0, 23'd0);
    push_sample(16'h00A1);
    push_sample(16'h00A2);
    repeat (6) @(negedge clk);
    pulse_pause();
    check_val("t4_paused", record_paused, 1);
    check_val("t4_ready_paused", record_audio_ready, 0);
    record_audio_valid = 1'b1;
    repeat (3) @(negedge clk);
    record_audio_valid = 1'b0;
    check_val("t4_no_overflow", record_overflow, 0);
    pulse_pause();
    check_val("t4_resumed", record_paused, 0);
    push_sample(16'h00A3);
    push_sample(16'h00A4);
    pulse_stop();
    wait_done("t4_done", 200);
    check_writes("t4", 4, 23'h7FFFFE, 16'h00A1, 16'd1);
    check_val("t4_nfresh", fresh_cnt - f0, 1);
    check_val("t4_length", record_length, 4);

    // Overflow: stalled write, continuous valid; one sample sits in the write
    // register and FIFO_DEPTH more fill the buffer.
    record_select[0] = 23'h000400;
    lat = 20;
    start_take(2'd0, 1'b0, 23'd0);
    accepted = 0;
    record_audio_data  = 16'h0010;
    record_audio_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      acc_now = record_audio_ready;
      @(negedge clk);
      if (acc_now) begin
        accepted++;
        record_audio_data = 16'(16'h0010 + accepted);
      end
    end
    check_val("t5_accepted", accepted, 9);
    check_val("t5_ready_full", record_audio_ready, 0);
    check_val("t5_overflow", record_overflow, 1);
    record_audio_valid = 1'b0;
    lat = 0;
    pulse_stop();
    wait_done("t5_done", 300);
    check_writes("t5", 9, 23'h000400, 16'h0010, 16'd1);
    check_val("t5_length", record_length, 9);
    check_val("t5_overflow_held", record_overflow, 1);

    // Reset in the middle of a write, then a clean take.
    record_select[0] = 23'h000500;
    lat = 20;
    start_take(2'd0, 1'b0, 23'd0);
    push_sample(16'h0055);
    wr_seen = 1'b0;
    for (int n = 0; n < 40 && !wr_seen; n++) begin
      wr_seen = record_write;
      if (!wr_seen) @(negedge clk);
    end
    check_val("t6_write_seen", wr_seen, 1);
    i_rst = 1'b0;
    #1;
    check_val("t6_rst_write", record_write, 0);
    check_val("t6_rst_busy", record_busy, 0);
    check_val("t6_rst_addr", record_addr, 0);
    check_val("t6_rst_length", record_length, 0);
    @(negedge clk);
    i_rst = 1'b1;
    lat = 0;
    repeat (2) @(negedge clk);
    start_take(2'd0, 1'b0, 23'd0);
    push_sample(16'h0061);
    push_sample(16'h0062);
    pulse_stop();
    wait_done("t6_done", 200);
    check_writes("t6", 2, 23'h000500, 16'h0061, 16'd1);
    check_val("t6_length", record_length, 2);
    check_val("t6_overflow", record_overflow, 0);

    check_val("rw_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
